// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder: widths, defaults,
// FSM state encoding and the captured request payload.
package dmem_pkg;

  localparam int unsigned WORD_W          = 32;
  localparam int unsigned LANES           = 4;
  localparam int unsigned DEF_DEPTH       = 1024;
  localparam int unsigned DEF_WAIT_STATES = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Operands latched at capture so later input changes cannot disturb the access.
  typedef struct packed {
    logic              we_re;
    logic [LANES-1:0]  mask;
    logic [WORD_W-1:0] data;
  } dmem_req_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Pipeline-to-responder data-memory request bus; the master is the memory stage.
interface data_mem_responder_if;
  import dmem_pkg::*;

  logic              request;
  logic              we_re;
  logic [31:0]       addr;
  logic [LANES-1:0]  mask;
  logic [WORD_W-1:0] store_data;
  logic [WORD_W-1:0] load_data;
  logic              ack;
  logic              err;
  logic              stall;

  modport master (
    output request, we_re, addr, mask, store_data,
    input  load_data, ack, err, stall
  );

  modport slave (
    input  request, we_re, addr, mask, store_data,
    output load_data, ack, err, stall
  );

endinterface

// File: rtl/data_mem_responder_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [LANES-1:0]         we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [WORD_W-1:0]        wdata,
  output logic [WORD_W-1:0]        rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // rdata only refreshes on pure reads so a store leaves the last loaded word intact.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
      if (we == '0) rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: captures one load/store, waits WAIT_STATES cycles,
// accesses the internal RAM and returns a one-cycle ack with the read word.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  mem
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = (WAIT_STATES == 0) ? 1 : $clog2(WAIT_STATES + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  dmem_req_t         op_q;
  logic [IDX_W-1:0]  idx_q;
  logic              oor_q;
  logic              ack_q;
  logic              err_q;
  logic              zero_q;
  logic              capture_c;
  logic              access_c;
  logic [31:0]       offset_c;
  logic [29:0]       widx_c;
  logic              in_range_c;
  logic              unused_lsb;
  logic              ram_en_c;
  logic [LANES-1:0]  ram_we_c;
  logic [WORD_W-1:0] ram_rdata;

  // Range check on the live address; only its captured result is ever used.
  assign offset_c   = mem.addr - BASE_ADDR;
  assign widx_c     = offset_c[31:2];
  assign unused_lsb = ^offset_c[1:0];
  assign in_range_c = (mem.addr >= BASE_ADDR) && ({2'b00, widx_c} < 32'(DEPTH));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture_c = 1'b0;
    access_c  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (mem.request) begin
          capture_c = 1'b1;
          cnt_d     = CNT_W'(WAIT_STATES);
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          access_c = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture_c) begin
        op_q.we_re <= mem.we_re;
        op_q.mask  <= mem.mask;
        op_q.data  <= mem.store_data;
        idx_q      <= widx_c[IDX_W-1:0];
        oor_q      <= !in_range_c;
      end
      ack_q <= access_c;
      err_q <= access_c && oor_q;
      // Loads decide whether the visible word is the RAM read or forced zero.
      if (access_c && !op_q.we_re) zero_q <= oor_q;
    end
  end

  // Empty-mask stores skip the RAM entirely so they cannot disturb rdata.
  assign ram_we_c = op_q.we_re ? op_q.mask : '0;
  assign ram_en_c = access_c && !oor_q && (!op_q.we_re || (op_q.mask != '0));

  dmem_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .en    (ram_en_c),
    .we    (ram_we_c),
    .idx   (idx_q),
    .wdata (op_q.data),
    .rdata (ram_rdata)
  );

  // load_data is a mux of two registers, so it carries no path from the inputs.
  assign mem.load_data = zero_q ? '0 : ram_rdata;
  assign mem.ack       = ack_q;
  assign mem.err       = err_q;
  assign mem.stall     = mem.request && !ack_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed cases plus random traffic
// checked against a word-array reference model.
module tb_data_mem_responder;
  import dmem_pkg::*;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WS    = 1;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int unsigned NPOOL = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if mem();

  data_mem_responder #(
    .DEPTH       (DEPTH),
    .BASE_ADDR   (BASE),
    .WAIT_STATES (WS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mem (mem)
  );

  typedef struct packed {
    logic [31:0] ld;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_m [DEPTH];
  logic [31:0] exp_ld;
  int unsigned pool_w [NPOOL];
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          held     = 1'b0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
  endtask

  // Reference model: word array, byte-lane merge, last-loaded word.
  task automatic model(input bit we, input logic [31:0] a, input logic [3:0] m,
                       input logic [31:0] d);
    exp_t        e;
    bit          oor;
    int unsigned idx;
    oor = (a < BASE) || (((a - BASE) >> 2) >= DEPTH);
    idx = (a - BASE) >> 2;
    if (!oor && we) begin
      for (int i = 0; i < 4; i++) begin
        if (m[i]) mem_m[idx][8*i +: 8] = d[8*i +: 8];
      end
    end
    if (!we) exp_ld = oor ? 32'h0 : mem_m[idx];
    e.ld  = exp_ld;
    e.err = oor;
    exp_q.push_back(e);
  endtask

  // Issue one transaction; if the previous one kept request high this is back-to-back.
  task automatic txn(input bit we, input logic [31:0] a, input logic [3:0] m,
                     input logic [31:0] d, input bit keep, input bit drop);
    int lat;
    int exp_lat;
    bit b2b;
    b2b     = held;
    exp_lat = b2b ? int'(WS) + 3 : int'(WS) + 2;
    if (!b2b) @(negedge clk);
    model(we, a, m, d);
    mem.request    = 1'b1;
    mem.we_re      = we;
    mem.addr       = a;
    mem.mask       = m;
    mem.store_data = d;
    if (!b2b) begin
      #1;
      check("stall_cycle0", 32'(mem.stall), 32'h1);
    end
    lat = 0;
    while (1) begin
      @(negedge clk);
      #1;
      lat++;
      if (drop && lat == 1) mem.request = 1'b0;
      if (mem.ack) break;
      if (lat > 64) begin
        check("ack_timeout", 32'(mem.ack), 32'h1);
        break;
      end
      if (!drop) check("stall_wait", 32'(mem.stall), 32'h1);
    end
    check("ack_latency", 32'(lat), 32'(exp_lat));
    check("stall_at_ack", 32'(mem.stall), 32'h0);
    if (!keep) mem.request = 1'b0;
    held = keep;
  endtask

  // Monitor: every ack consumes exactly one expected response.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst && mem.ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'(mem.ack), 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("load_data", mem.load_data, e.ld);
        check("err", 32'(mem.err), 32'(e.err));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mem.request    = 1'b0;
    mem.we_re      = 1'b0;
    mem.addr       = '0;
    mem.mask       = '0;
    mem.store_data = '0;
    exp_ld         = '0;
    for (int i = 0; i < 16; i++) pool_w[i] = i;
    for (int i = 16; i < int'(NPOOL); i++) pool_w[i] = DEPTH - NPOOL + i;

    // Reset values; stall follows request while in reset.
    repeat (2) @(negedge clk);
    #1;
    check("rst_ack", 32'(mem.ack), 32'h0);
    check("rst_err", 32'(mem.err), 32'h0);
    check("rst_load_data", mem.load_data, 32'h0);
    mem.request = 1'b1;
    #1;
    check("rst_stall_hi", 32'(mem.stall), 32'h1);
    mem.request = 1'b0;
    #1;
    check("rst_stall_lo", 32'(mem.stall), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Give every pool word a known value.
    for (int i = 0; i < int'(NPOOL); i++)
      txn(1'b1, BASE + 32'(pool_w[i] * 4), 4'hF, $urandom, 1'b0, 1'b0);

    // Store then load.
    txn(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0);
    txn(1'b0, 32'h10, 4'h0, 32'h0, 1'b0, 1'b0);

    // Byte-masked store.
    txn(1'b1, 32'h20, 4'hF, 32'h11223344, 1'b0, 1'b0);
    txn(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 1'b0, 1'b0);
    txn(1'b0, 32'h20, 4'h0, 32'h0, 1'b0, 1'b0);

    // Out of range, empty mask, and top-of-RAM boundary.
    txn(1'b0, 32'h1000, 4'h0, 32'h0, 1'b0, 1'b0);
    txn(1'b1, 32'h1000, 4'hF, 32'hCAFEF00D, 1'b0, 1'b0);
    txn(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    txn(1'b1, 32'h10, 4'h0, 32'h12345678, 1'b0, 1'b0);
    txn(1'b0, 32'h10, 4'h0, 32'h0, 1'b0, 1'b0);
    txn(1'b1, 32'hFFC, 4'hF, 32'h0BADC0DE, 1'b0, 1'b0);
    txn(1'b0, 32'hFFE, 4'h0, 32'h0, 1'b0, 1'b0);

    // Three back-to-back loads with request held throughout.
    txn(1'b0, 32'h10, 4'h0, 32'h0, 1'b1, 1'b0);
    txn(1'b0, 32'h20, 4'h0, 32'h0, 1'b1, 1'b0);
    txn(1'b0, 32'h04, 4'h0, 32'h0, 1'b0, 1'b0);

    // Request dropped after capture: the store still commits.
    txn(1'b1, 32'h08, 4'hF, 32'h5A5A_A5A5, 1'b0, 1'b1);
    txn(1'b0, 32'h08, 4'h0, 32'h0, 1'b0, 1'b0);

    // Reset while BUSY, before the access edge.
    @(negedge clk);
    mem.request    = 1'b1;
    mem.we_re      = 1'b1;
    mem.addr       = 32'h0C;
    mem.mask       = 4'hF;
    mem.store_data = ~mem_m[3];
    @(negedge clk);
    #1;
    rst         = 1'b0;
    mem.request = 1'b0;
    #1;
    check("midrst_ack", 32'(mem.ack), 32'h0);
    check("midrst_err", 32'(mem.err), 32'h0);
    check("midrst_load_data", mem.load_data, 32'h0);
    @(negedge clk);
    rst    = 1'b1;
    exp_ld = 32'h0;
    @(negedge clk);
    #1;
    check("postrst_load_data", mem.load_data, 32'h0);
    check("postrst_ack", 32'(mem.ack), 32'h0);
    txn(1'b0, 32'h0C, 4'h0, 32'h0, 1'b0, 1'b0);

    // Random traffic over the pool plus out-of-range addresses.
    for (int k = 0; k < 160; k++) begin
      bit          we;
      bit          keep;
      bit          drop;
      int unsigned sel;
      logic [31:0] a;
      we  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, NPOOL + 2);
      if (sel < NPOOL)          a = BASE + 32'(pool_w[sel] * 4) + 32'($urandom_range(0, 3));
      else if (sel == NPOOL)    a = 32'h0000_1000;
      else if (sel == NPOOL + 1) a = 32'h2000_0000;
      else                      a = 32'hFFFF_FFFC;
      keep = (k != 159) && ($urandom_range(0, 3) == 0);
      drop = !held && !keep && ($urandom_range(0, 7) == 0);
      txn(we, a, 4'($urandom_range(0, 15)), $urandom, keep, drop);
    end

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder side of the data-memory request interface driven by the pipeline's memory stage. Accepts load/store requests (request, we_re, byte mask, word address, store data) and services them against an internal word-organised RAM with a configurable number of wait states. Returns the full 32-bit word on loads and a one-cycle acknowledge, so the pipeline can stall on `stall` until then. Sub-word extraction and sign extension stay in the memory stage's load/store wrapper; this block deals only in aligned words and byte lanes.

## Interface
- `DEPTH`, 1024: RAM size in 32-bit words; power of two.
- `BASE_ADDR`, 32'h0000_0000: byte address mapped to word 0.
- `WAIT_STATES`, 1: extra cycles between capture and access; 0..15.
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `request` in 1: transaction request; held high with operands stable until `ack`.
- `we_re` in 1: 1 = store, 0 = load; sampled with `request`.
- `addr` in 32: byte address from ALU; bits [1:0] ignored.
- `mask` in 4: byte-lane write enables, bit i covers bits [8i+7:8i]; ignored for loads.
- `store_data` in 32: lane-aligned write data.
- `load_data` out 32: read word; valid in the `ack` cycle, held until the next `ack`.
- `ack` out 1: one-cycle completion pulse.
- `err` out 1: address out of range; meaningful only when `ack` is high.
- `stall` out 1: `request && !ack`; combinational; used as the pipeline hold.

## Operation
- States:
  - IDLE: capture `we_re`, word index, `mask` and `store_data` into registers when `request` is high; go to BUSY with `cnt = WAIT_STATES`.
  - BUSY: if `cnt != 0`, decrement. If `cnt == 0`, perform the access on this edge and go to DONE.
  - DONE: `ack = 1` for exactly one cycle, then go to IDLE.
- Word index = `(addr - BASE_ADDR) >> 2`. The address is out of range if `addr < BASE_ADDR` or the index is `>= DEPTH`.
- Store access:
  - Write only the lanes whose `mask` bit is 1. Other lanes are unchanged.
  - `mask == 0` modifies nothing and is still acknowledged.
  - `load_data` is unchanged.
- Load access: `load_data` = full RAM word.
- Out-of-range access:
  - No RAM write.
  - `load_data` = 0.
  - `err = 1` with `ack`.
- Operands are registered at capture. Input changes after capture are ignored.
- `request` dropping while BUSY/DONE does not abort; the transaction completes and the store commits.
- RAM contents are not reset. Only control and output registers reset.

## Timing
- Reset values (asynchronous, while `rst == 0`):
  - state = IDLE, `cnt` = 0
  - `ack` = 0, `err` = 0, `load_data` = 0
  - `stall` then follows `request`.
- Latency: `request` first high in IDLE cycle 0 gives `ack` high in cycle `WAIT_STATES + 2`. With `WAIT_STATES = 0`, `ack` is in cycle 2.
- Throughput: one transaction per `WAIT_STATES + 3` cycles.
- Back-to-back requests:
  - If `request` is still high in the cycle after `ack`, it is a new transaction and is captured in that IDLE cycle.
  - The initiator must deassert or change operands in the cycle after `ack`.
- Reset mid-transaction:
  - Abort to IDLE with no `ack`.
  - A store that has not reached its access edge is not committed.
  - A store whose access edge occurred is committed.
- `ack` and `err` are registered outputs. No combinational path from inputs to `ack`, `err` or `load_data`.

## Structure
- Package `dmem_pkg`:
  - state encodings IDLE/BUSY/DONE (2 bits)
  - default `DEPTH`/`WAIT_STATES`
  - `WORD_W = 32`, `LANES = 4`
- Sub-module `dmem_ram`: single-port synchronous RAM with per-byte write enable. Ports are clk, en, we[3:0], idx, wdata, rdata; no reset. The read is registered in the same edge as the access.
- Top: FSM, wait counter (`$clog2(WAIT_STATES+1)` bits, minimum 1), operand registers, range check.

## Test plan
- Store then load, `WAIT_STATES=1`:
  - Store 32'hDEADBEEF, `mask` 4'hF to 0x10, hold `request`: `ack` in cycle 3, `stall` high in cycles 0–2.
  - Then load 0x10: `load_data` = 32'hDEADBEEF with `ack`.
- Byte-masked store: preload 0x20 = 32'h11223344, store 32'hAABBCCDD with `mask` 4'b0101, load 0x20 → 32'h11BB33DD.
- Out of range, `DEPTH=1024`:
  - Load 0x1000: `ack` with `err=1`, `load_data`=0.
  - Store to 0x1000 then load 0x0: word 0 is unchanged.
- Back-to-back `WAIT_STATES=0`: three loads with `request` held continuously and operands changed after each `ack` → acks in cycles 2, 5, 8 with the correct data.
- Robustness:
  - `request` dropped after capture: the store still commits and `ack` still pulses once.
  - `rst` pulsed low while BUSY before the access edge: `ack` is never asserted, the store is not committed, and outputs read 0.
